// File: rtl/serial_sub_pkg.sv
// Shared arithmetic package for serial_sub: state encoding and counter sizing.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Digit-counter width: ceil(log2(k)), never less than one bit.
    function automatic int cnt_width(input int k);
        return (k <= 2) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/serial_sub_fs_cell.sv
// 1-bit full subtractor cell: d = a - b - bin, with borrow out.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b, bin (inputs); d (difference bit), bout (borrow out).
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or a == b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Digit-serial subtractor: diff = a - b - bin mod 2^WIDTH, DIGIT bits per clock.
// Latency: K = WIDTH/DIGIT cycles from the accepting edge to the done pulse.
// Backpressure: start is accepted only while busy = 0; start during RUN is dropped.
// Ports: clk, rst_n (async, active-low), start, a, b, bin in; busy, done, diff, bout out;
//        ovf (signed overflow) exists only when SERIAL_SUB_OVF_EN is defined.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = cnt_width(K);
    // Holds the already-finished low slices; the newest slice is appended on commit.
    localparam int RW = (K > 1) ? (WIDTH - DIGIT) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_sub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [RW-1:0]     res_q, res_d;
    logic              brw_q, brw_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic              ovf_q, ovf_d;
`endif

    // Per-cycle ripple: DIGIT cells chained from the registered borrow.
    logic [DIGIT-1:0]  slice;
    logic [DIGIT:0]    chain;
    logic [WIDTH-1:0]  res_full;
    logic              last_digit;

    assign chain[0] = brw_q;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_cell
            fs_cell u_cell (
                .a    (a_sh_q[i]),
                .b    (b_sh_q[i]),
                .bin  (chain[i]),
                .d    (slice[i]),
                .bout (chain[i+1])
            );
        end

        // Slices arrive LSB first, so each new slice lands above the older ones.
        if (K > 1) begin : g_multi
            assign res_full = {slice, res_q};
        end else begin : g_single
            assign res_full = slice;
        end
    endgenerate

    assign last_digit = (cnt_q == CW'(K - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    res_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> DIGIT;
                b_sh_d = b_sh_q >> DIGIT;
                res_d  = RW'(res_full >> DIGIT);
                brw_d  = chain[DIGIT];
                cnt_d  = cnt_q + 1'b1;
                if (last_digit) begin
                    state_d = S_DONE;
                    diff_d  = res_full;
                    bout_d  = chain[DIGIT];
`ifdef SERIAL_SUB_OVF_EN
                    // Operands of opposite sign whose result sign differs from the minuend.
                    ovf_d   = (a_msb_q != b_msb_q) && (res_full[WIDTH-1] != a_msb_q);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: an 8-bit/1-digit and a 16-bit/4-digit instance driven in turn.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_sub;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        start0 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0;
    logic        bin0 = 1'b0;
    logic        busy0, done0, bout0;
    logic [7:0]  diff0;

    logic        start1 = 1'b0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        bin1 = 1'b0;
    logic        busy1, done1, bout1;
    logic [15:0] diff1;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf0, ovf1;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] exp_diff;
    logic        exp_bout;
    logic        exp_ovf;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .bin(bin0),
        .busy(busy0), .done(done0), .diff(diff0), .bout(bout0)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf0)
`endif
    );

    serial_sub #(.WIDTH(16), .DIGIT(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction
    function automatic logic cur_done(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction
    function automatic logic cur_bout(input int sel);
        return (sel == 0) ? bout0 : bout1;
    endfunction
    function automatic logic [15:0] cur_diff(input int sel);
        return (sel == 0) ? {8'h00, diff0} : diff1;
    endfunction
`ifdef SERIAL_SUB_OVF_EN
    function automatic logic cur_ovf(input int sel);
        return (sel == 0) ? ovf0 : ovf1;
    endfunction
`endif
    function automatic int k_of(input int sel);
        return (sel == 0) ? 8 : 4;
    endfunction

    // Reference: plain integer subtraction, then wrap to the instance width.
    task automatic model(input int sel, input logic [15:0] aa, input logic [15:0] bb, input logic bi);
        int          w;
        int          d;
        logic [15:0] mask;
        logic [15:0] am, bm;
        w    = (sel == 0) ? 8 : 16;
        mask = 16'((32'd1 << w) - 1);
        am   = aa & mask;
        bm   = bb & mask;
        d    = int'(am) - int'(bm) - int'(bi);
        exp_bout = (d < 0);
        exp_diff = 16'(d) & mask;
        exp_ovf  = (am[w-1] != bm[w-1]) && (exp_diff[w-1] != am[w-1]);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic start_op(input int sel, input logic [15:0] aa, input logic [15:0] bb, input logic bi);
        model(sel, aa, bb, bi);
        if (sel == 0) begin
            a0 = aa[7:0]; b0 = bb[7:0]; bin0 = bi; start0 = 1'b1;
        end else begin
            a1 = aa; b1 = bb; bin1 = bi; start1 = 1'b1;
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        chk("accept_busy", 32'(cur_busy(sel)), 32'd1);
        chk("accept_done", 32'(cur_done(sel)), 32'd0);
    endtask

    // Waits (bounded) for done; 'remaining' is the number of edges still expected.
    task automatic wait_done(input int sel, input int remaining, input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < remaining + 4) begin
            @(posedge clk); #1;
            n++;
            if (cur_done(sel)) seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(n), 32'(remaining));
        chk({tag, "_diff"}, 32'(cur_diff(sel)), 32'(exp_diff));
        chk({tag, "_bout"}, 32'(cur_bout(sel)), 32'(exp_bout));
        chk({tag, "_busy_at_done"}, 32'(cur_busy(sel)), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(cur_ovf(sel)), 32'(exp_ovf));
`endif
    endtask

    initial begin
        logic [15:0] prev;
        int          sel;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_diff0", 32'(diff0), 32'd0);
        chk("rst_bout0", 32'(bout0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_diff1", 32'(diff1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic operation with exact latency
        start_op(0, 16'h35, 16'h12, 1'b0);
        wait_done(0, 8, "op35");
        chk("op35_const", 32'(diff0), 32'h23);
        @(posedge clk); #1;
        chk("done_single_pulse", 32'(done0), 32'd0);
        chk("diff_held_idle", 32'(diff0), 32'h23);

        // Wrap-around, then back-to-back ops with bin
        start_op(0, 16'h00, 16'h01, 1'b0);
        wait_done(0, 8, "wrap");
        chk("wrap_const", 32'({bout0, diff0}), 32'h1FF);
        start_op(0, 16'h10, 16'h0F, 1'b1);
        wait_done(0, 8, "b2b_bin");
        chk("b2b_bin_const", 32'({bout0, diff0}), 32'h000);
        start_op(0, 16'h5A, 16'h5A, 1'b1);
        wait_done(0, 8, "eq_bin");
        chk("eq_bin_const", 32'({bout0, diff0}), 32'h1FF);

        // start during RUN is ignored; diff holds the previous result meanwhile
        @(posedge clk); #1;
        prev = exp_diff;
        start_op(0, 16'hC3, 16'h4E, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_during_run", 32'(diff0), 32'(prev));
        a0 = 8'h01; b0 = 8'hF0; bin0 = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("ignore_busy", 32'(busy0), 32'd1);
        wait_done(0, 4, "ignore");
        start_op(0, 16'h01, 16'hF0, 1'b1);
        wait_done(0, 8, "b2b_after_ignore");

        // Reset in the middle of RUN
        @(posedge clk); #1;
        start_op(0, 16'h99, 16'h11, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_done", 32'(done0), 32'd0);
        chk("midrst_diff", 32'(diff0), 32'd0);
        chk("midrst_bout", 32'(bout0), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("midrst_ovf", 32'(ovf0), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(busy0), 32'd0);
        start_op(0, 16'h35, 16'h12, 1'b0);
        wait_done(0, 8, "post_rst");

        // Wide instance, 4 bits per cycle
        start_op(1, 16'h1234, 16'h4321, 1'b0);
        wait_done(1, 4, "w16");
        chk("w16_const", 32'({bout1, diff1}), 32'h1CF13);

`ifdef SERIAL_SUB_OVF_EN
        start_op(0, 16'h80, 16'h01, 1'b0);
        wait_done(0, 8, "ovf_set");
        chk("ovf_set_const", 32'({ovf0, diff0}), 32'h17F);
        start_op(0, 16'h7F, 16'h01, 1'b0);
        wait_done(0, 8, "ovf_clr");
        chk("ovf_clr_const", 32'(ovf0), 32'd0);
`endif

        // Randomized ops on both instances, with and without idle gaps
        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(0, 1));
            start_op(sel, 16'($urandom), 16'($urandom), 1'($urandom));
            wait_done(sel, k_of(sel), "rnd");
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                chk("rnd_done_drop", 32'(cur_done(sel)), 32'd0);
                chk("rnd_diff_hold", 32'(cur_diff(sel)), 32'(exp_diff));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
